// File: rtl/idec_pipe_if.sv
// idec_pipe_if: fetch-side and execute-side handshakes of the decode stage.
//   slave  : decoder view (takes the instruction beat, drives the decoded beat)
//   master : environment view (fetch drives in_*, execute drives out_ready)
// Signals:
//   in_valid/in_ready/in_instr/in_pc        instruction beat from fetch
//   out_valid/out_ready                     decoded-beat handshake
//   out_alu/out_rn/out_rd/out_imm/out_op2   operand fields
//   out_s/out_reg_we/out_mem_we/out_ib/out_bl/out_bv/out_und  control
interface idec_pipe_if #(
    parameter int PC_W   = 32,
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_alu;
    logic [REG_AW-1:0] out_rn;
    logic [REG_AW-1:0] out_rd;
    logic              out_imm;
    logic [11:0]       out_op2;
    logic              out_s;
    logic              out_reg_we;
    logic              out_mem_we;
    logic              out_ib;
    logic              out_bl;
    logic [PC_W-1:0]   out_bv;
    logic              out_und;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu, out_rn, out_rd, out_imm, out_op2,
               out_s, out_reg_we, out_mem_we, out_ib, out_bl, out_bv, out_und
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu, out_rn, out_rd, out_imm, out_op2,
               out_s, out_reg_we, out_mem_we, out_ib, out_bl, out_bv, out_und
    );
endinterface

// File: rtl/idec_pipe.sv
// idec_pipe: one-stage pipelined instruction decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   cpsr_in    : {N,Z,C,V} used for the condition check of the accepted beat
//   flags_wb   : pulse, one flag-setting instruction has written CPSR
//   flush      : drop the held output and any pending squash
//   bus        : idec_pipe_if.slave, instruction in / decoded beat out
// A conditional instruction is held while any flag-setting instruction is in
// flight so it always sees final flags. After a taken branch the next
// SQUASH_N fetch beats are wrong-path and are swallowed.
module idec_pipe #(
    parameter int PC_W     = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_PEND = 3,
    parameter int SQUASH_N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   cpsr_in,
    input  logic         flags_wb,
    input  logic         flush,
    idec_pipe_if.slave   bus
);
    localparam int PW = (MAX_PEND < 1) ? 1 : $clog2(MAX_PEND + 1);
    localparam int SW = (SQUASH_N < 1) ? 1 : $clog2(SQUASH_N + 1);
    localparam int XW = PC_W + 32;

    typedef enum logic {RUN, SQUASH} state_t;

    typedef struct packed {
        logic [3:0]        alu;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rd;
        logic              imm;
        logic [11:0]       op2;
        logic              s;
        logic              reg_we;
        logic              mem_we;
        logic              ib;
        logic              bl;
        logic [PC_W-1:0]   bv;
        logic              und;
    } dec_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   sq_cnt, sq_nxt;
    logic [PW-1:0]   pcnt;
    logic            out_v;
    dec_t            q, d;
    logic            pass, hold, rdy, load, is_br;
    logic [31:0]     ins;
    logic [REG_AW+3:0] rn_z, rd_z;
    logic [XW-1:0]   bv_x;

    assign ins  = bus.in_instr;
    // Zero-extend first, then take the low REG_AW bits: covers both widening
    // and truncating register index widths.
    assign rn_z = {{REG_AW{1'b0}}, ins[19:16]};
    assign rd_z = {{REG_AW{1'b0}}, ins[15:12]};
    assign bv_x = XW'(bus.in_pc) + XW'(8) + XW'(signed'({ins[23:0], 2'b00}));
    assign is_br = (ins[27:25] == 3'b101);

    // Condition check against the live CPSR.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = cpsr_in;
        pass = 1'b0;
        case (ins[31:28])
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_comb begin
        d        = '0;
        d.alu    = ins[24:21];
        d.rn     = rn_z[REG_AW-1:0];
        d.rd     = rd_z[REG_AW-1:0];
        d.imm    = ins[25];
        d.op2    = ins[11:0];
        case (ins[27:25])
            3'b000, 3'b001: begin
                d.reg_we = 1'b1;
                d.s      = ins[20];
            end
            3'b010, 3'b011: begin
                d.reg_we = ins[20];
                d.mem_we = !ins[20];
            end
            3'b101: begin
                d.alu    = '0;
                d.rn     = '0;
                d.rd     = '0;
                d.reg_we = 1'b1;
                d.ib     = 1'b1;
                d.bl     = ins[24];
                d.bv     = bv_x[PC_W-1:0];
            end
            default: d.und = 1'b1;
        endcase
    end

    // Conditional beats wait for in-flight flag writers; flag setters wait
    // for a free pending slot.
    assign hold = ((ins[31:28] != 4'hE) && (pcnt != '0)) ||
                  (pass && d.s && (pcnt == PW'(MAX_PEND)));

    always_comb begin
        state_nxt = state;
        sq_nxt    = sq_cnt;
        rdy       = 1'b0;
        case (state)
            RUN: begin
                rdy = (!out_v || bus.out_ready) && !hold;
                if (bus.in_valid && rdy && pass && is_br && (SQUASH_N != 0)) begin
                    state_nxt = SQUASH;
                    sq_nxt    = SW'(SQUASH_N);
                end
            end
            SQUASH: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    sq_nxt = sq_cnt - SW'(1);
                    if (sq_cnt == SW'(1)) state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (flush) begin
            rdy       = 1'b0;
            state_nxt = RUN;
            sq_nxt    = '0;
        end
    end

    assign load = bus.in_valid && rdy && pass && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else if (load) begin
            out_v <= 1'b1;
            q     <= d;
        end else if (bus.out_ready) begin
            out_v <= 1'b0;
        end
    end

    // Pending flag-writer count; events in the same cycle net out, and the
    // result never goes below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        logic [PW:0] up, dn;
        if (!rst_n) begin
            pcnt <= '0;
        end else begin
            up = {1'b0, pcnt} + (PW+1)'(load && d.s);
            dn = (PW+1)'(flags_wb && (pcnt != '0)) + (PW+1)'(flush && out_v && q.s);
            pcnt <= (up > dn) ? PW'(up - dn) : '0;
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = out_v;
    assign bus.out_alu    = q.alu;
    assign bus.out_rn     = q.rn;
    assign bus.out_rd     = q.rd;
    assign bus.out_imm    = q.imm;
    assign bus.out_op2    = q.op2;
    assign bus.out_s      = q.s;
    assign bus.out_reg_we = q.reg_we;
    assign bus.out_mem_we = q.mem_we;
    assign bus.out_ib     = q.ib;
    assign bus.out_bl     = q.bl;
    assign bus.out_bv     = q.bv;
    assign bus.out_und    = q.und;
endmodule

// File: tb/tb_idec_pipe.sv
module tb_idec_pipe;
    localparam int MAXP = 3;
    localparam int SQN  = 2;

    localparam logic [31:0] I_ADD   = 32'hE0821003;
    localparam logic [31:0] I_ADDS  = 32'hE0921003;
    localparam logic [31:0] I_MOVEQ = 32'h03A01001;
    localparam logic [31:0] I_BL    = 32'hEB000004;

    typedef struct packed {
        logic [3:0]  alu;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic        imm;
        logic [11:0] op2;
        logic        s;
        logic        reg_we;
        logic        mem_we;
        logic        ib;
        logic        bl;
        logic [31:0] bv;
        logic        und;
    } dec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] cpsr;
    logic       fwb;
    logic       flush;

    idec_pipe_if #(.PC_W(32), .REG_AW(4)) bus ();

    idec_pipe #(.PC_W(32), .REG_AW(4), .MAX_PEND(MAXP), .SQUASH_N(SQN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpsr_in  (cpsr),
        .flags_wb (fwb),
        .flush    (flush),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    dec_t sb[$];
    int   m_pcnt;
    int   m_sq;
    logic m_ov;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic dec_t m_dec(input logic [31:0] i, input logic [31:0] pc);
        dec_t r;
        r = '0;
        r.alu = i[24:21];
        r.rn  = i[19:16];
        r.rd  = i[15:12];
        r.imm = i[25];
        r.op2 = i[11:0];
        if (i[27:26] == 2'b00) begin
            r.reg_we = 1'b1;
            r.s      = i[20];
        end else if (i[27:26] == 2'b01) begin
            r.reg_we = i[20];
            r.mem_we = !i[20];
        end else if (i[27:25] == 3'b101) begin
            r.alu = 4'h0; r.rn = 4'h0; r.rd = 4'h0;
            r.reg_we = 1'b1;
            r.ib  = 1'b1;
            r.bl  = i[24];
            r.bv  = pc + 32'd8 + {{6{i[23]}}, i[23:0], 2'b00};
        end else begin
            r.und = 1'b1;
        end
        return r;
    endfunction

    function automatic dec_t dut_out();
        dec_t r;
        r.alu = bus.out_alu;   r.rn = bus.out_rn;   r.rd = bus.out_rd;
        r.imm = bus.out_imm;   r.op2 = bus.out_op2; r.s = bus.out_s;
        r.reg_we = bus.out_reg_we; r.mem_we = bus.out_mem_we;
        r.ib = bus.out_ib;     r.bl = bus.out_bl;   r.bv = bus.out_bv;
        r.und = bus.out_und;
        return r;
    endfunction

    task automatic m_reset();
        sb.delete();
        m_pcnt = 0;
        m_sq   = 0;
        m_ov   = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    // Returns mid-cycle so callers can inspect the same cycle's signals.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic fw, input logic [3:0] cp);
        logic er, pass, s_i, hold, acc, fs, ov_old;
        int   dn;
        @(negedge clk);
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy;
        flush = fl; fwb = fw; cpsr = cp;
        #1;
        pass = m_cond(ins[31:28], cp);
        s_i  = (ins[27:26] == 2'b00) && ins[20];
        hold = (ins[31:28] != 4'hE && m_pcnt != 0) || (pass && s_i && m_pcnt == MAXP);
        if (fl)             er = 1'b0;
        else if (m_sq != 0) er = 1'b1;
        else                er = (!m_ov || ordy) && !hold;
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        fs = 1'b0;
        if (m_ov && sb.size() > 0) begin
            fs = sb[0].s;
            if (fl) void'(sb.pop_front());
            else if (ordy) chk("out_data", 64'(dut_out()), 64'(sb.pop_front()));
        end
        ov_old = m_ov;
        if (fl || (m_ov && ordy)) m_ov = 1'b0;
        acc = v && er;
        dn = 0;
        if (fw && m_pcnt != 0) dn++;
        if (fl && ov_old && fs) dn++;
        if (acc && pass && s_i && m_sq == 0) m_pcnt++;
        m_pcnt = (m_pcnt > dn) ? m_pcnt - dn : 0;
        if (fl) m_sq = 0;
        else if (m_sq != 0) begin
            if (v) m_sq--;
        end else if (acc && pass) begin
            sb.push_back(m_dec(ins, pc));
            m_ov = 1'b1;
            if (ins[27:25] == 3'b101) m_sq = SQN;
        end
    endtask

    task automatic idle(input logic ordy, input logic fw);
        cyc(1'b0, 32'h0, 32'h0, ordy, 1'b0, fw, 4'h0);
    endtask

    initial begin
        logic [31:0] ri;
        rst_n = 1'b0; cpsr = 4'h0; fwb = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b1;
        m_reset();
        #2;
        chk("rst_ov", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(dut_out()), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // ADD r1,r2,r3
        cyc(1'b1, I_ADD, 32'h100, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(1'b1, 1'b0);
        chk("add_ov", 64'(bus.out_valid), 64'd1);
        chk("add_alu", 64'(bus.out_alu), 64'h4);
        chk("add_rn", 64'(bus.out_rn), 64'h2);
        chk("add_rd", 64'(bus.out_rd), 64'h1);
        chk("add_we_s", 64'({bus.out_reg_we, bus.out_s}), 64'b10);

        // BL +0x10, then two squashed beats and one emitted
        cyc(1'b1, I_BL, 32'h200, 1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, I_ADD, 32'h204, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("bl_bv", 64'(bus.out_bv), 64'h218);
        chk("bl_ib_bl", 64'({bus.out_ib, bus.out_bl}), 64'b11);
        cyc(1'b1, I_ADD, 32'h208, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("sq1_ov", 64'(bus.out_valid), 64'd0);
        cyc(1'b1, I_ADD, 32'h20C, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("sq2_ov", 64'(bus.out_valid), 64'd0);
        idle(1'b1, 1'b0);
        chk("post_sq_ov", 64'(bus.out_valid), 64'd1);

        // ADDS then MOVEQ: held until flags_wb, Z=1 emits, Z=0 drops
        for (int k = 0; k < 2; k++) begin
            logic [3:0] cz;
            cz = (k == 0) ? 4'b0100 : 4'b0000;
            cyc(1'b1, I_ADDS, 32'h300, 1'b1, 1'b0, 1'b0, 4'h0);
            for (int h = 0; h < 3; h++) begin
                cyc(1'b1, I_MOVEQ, 32'h304, 1'b1, 1'b0, 1'b0, cz);
                chk("moveq_hold", 64'(bus.in_ready), 64'd0);
            end
            cyc(1'b1, I_MOVEQ, 32'h304, 1'b1, 1'b0, 1'b1, cz);
            chk("moveq_hold_wb", 64'(bus.in_ready), 64'd0);
            cyc(1'b1, I_MOVEQ, 32'h304, 1'b1, 1'b0, 1'b0, cz);
            chk("moveq_go", 64'(bus.in_ready), 64'd1);
            idle(1'b1, 1'b0);
            chk("moveq_ov", 64'(bus.out_valid), 64'(k == 0));
            if (k == 0) chk("moveq_alu_rd", 64'({bus.out_alu, bus.out_rd}), 64'hD1);
        end

        // Pending counter saturation
        for (int k = 0; k < 3; k++) cyc(1'b1, I_ADDS, 32'h400, 1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, I_ADDS, 32'h40C, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("adds4_stall", 64'(bus.in_ready), 64'd0);
        cyc(1'b1, I_ADDS, 32'h40C, 1'b1, 1'b0, 1'b1, 4'h0);
        chk("adds4_stall_wb", 64'(bus.in_ready), 64'd0);
        cyc(1'b1, I_ADDS, 32'h40C, 1'b1, 1'b0, 1'b1, 4'h0);
        chk("adds4_go_wb", 64'(bus.in_ready), 64'd1);
        cyc(1'b1, I_ADDS, 32'h410, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("adds5_go", 64'(bus.in_ready), 64'd1);
        cyc(1'b1, I_ADDS, 32'h414, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("adds6_stall", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b1);

        // Flush of a held ADDS
        cyc(1'b1, I_ADDS, 32'h500, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(1'b0, 1'b0);
        chk("hold_ov", 64'(bus.out_valid), 64'd1);
        cyc(1'b1, I_ADD, 32'h504, 1'b0, 1'b1, 1'b0, 4'h0);
        chk("flush_rdy", 64'(bus.in_ready), 64'd0);
        cyc(1'b1, I_MOVEQ, 32'h508, 1'b1, 1'b0, 1'b0, 4'b0100);
        chk("flush_ov", 64'(bus.out_valid), 64'd0);
        chk("flush_pcnt0", 64'(bus.in_ready), 64'd1);
        idle(1'b1, 1'b0);

        // Reset mid-stream with a held instruction
        cyc(1'b1, I_ADD, 32'h600, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(1'b0, 1'b0);
        chk("prerst_ov", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 64'(bus.out_valid), 64'd0);
        chk("midrst_data", 64'(dut_out()), 64'd0);
        m_reset();
        @(negedge clk); rst_n = 1'b1;
        idle(1'b1, 1'b0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            ri = $urandom;
            if ($urandom_range(0, 2) != 0) ri[31:28] = 4'hE;
            if ($urandom_range(0, 7) == 0) ri[27:25] = 3'b101;
            cyc($urandom_range(0, 3) != 0, ri, {$urandom} & 32'hFFFF_FFFC,
                $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 3) == 0, 4'($urandom));
        end
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/idec_pipe.md
# idec_pipe

Pipelined, parametrised successor to the single-cycle instruction decoder: a decode stage with valid/ready handshakes on both sides, registered decoded outputs, condition evaluation against CPSR, and a flag-hazard interlock. It also squashes wrong-path fetch slots after a taken branch. It sits between the fetch stage and the register-read/execute stage of the CPU.

## Interface
- PC_W, 32, width of PC and branch target
- REG_AW, 4, register index width
- MAX_PEND, 3, max in-flight flag-setting instructions (counter saturation point)
- SQUASH_N, 2, wrong-path input beats discarded after a taken branch
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction beat valid
- in_ready  out  1  decoder accepts beat this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- cpsr_in  in  4  {N,Z,C,V}
- flags_wb  in  1  one-cycle pulse: one flag-setting instruction has written CPSR
- flush  in  1  discard held output and squash state
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_alu  out  4  instr[24:21] for data/load-store, 0 for branch
- out_rn, out_rd  out  REG_AW  instr[19:16], instr[15:12] (zero-extended or truncated to REG_AW)
- out_imm  out  1  instr[25]
- out_op2  out  12  instr[11:0]
- out_s  out  1  CPSR-set (data processing only)
- out_reg_we, out_mem_we, out_ib, out_bl  out  1 each  as decoded below
- out_bv  out  PC_W  branch target
- out_und  out  1  undefined class

## Operation
- Class from instr[27:25]: 000/001 data processing; 010/011 load/store; 101 branch; others undefined.
- Data processing: reg_we=1, mem_we=0, s=instr[20].
- Load/store: reg_we=instr[20], mem_we=~instr[20], s=0.
- Branch: reg_we=1, ib=1, bl=instr[24], alu/rn/rd=0, bv = in_pc + 8 + sext(instr[23:0]<<2), mod 2^PC_W.
- Undefined: und=1, every other control bit 0.
- Condition instr[31:28], standard ARM semantics:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 never.
- Failed condition: beat is consumed, nothing emitted, no counter or state change.
- Pending counter pcnt (0..MAX_PEND):
  - +1 when a passing S=1 instruction is accepted.
  - −1 on flags_wb (ignored when pcnt=0).
  - −1 on flush if out_valid&&out_s.
  - Simultaneous events sum.
- Hold conditions (in_ready=0 in RUN):
  - cond≠AL and pcnt≠0.
  - Passing S=1 instruction and pcnt=MAX_PEND.
  - in_ready may depend on in_instr.
- FSM RUN/SQUASH:
  - Accepting a passing branch loads sq_cnt=SQUASH_N and goes to SQUASH.
  - SQUASH: in_ready=1; each in_valid beat is discarded and decrements sq_cnt; at 0 → RUN.
  - SQUASH_N=0 never enters SQUASH.
- Slot: in RUN, in_ready = (!out_valid || out_ready) && !hold; the output register loads on in_valid&&in_ready&&pass.
- flush has priority:
  - out_valid→0, state→RUN, sq_cnt→0, in_ready=0 in that cycle.
  - flags_wb is still honoured in the flush cycle.

## Timing
- Latency 1: a beat accepted at edge k is presented on out_* after edge k, held stable while out_valid&&!out_ready.
- Full throughput, 1 instr/cycle, when no hold and out_ready=1.
- Condition uses the cpsr_in value sampled in the acceptance cycle.
- Reset (async assert, sync release on clk): out_valid=0, all out_* data=0, pcnt=0, sq_cnt=0, state RUN.
- Reset mid-operation drops any held instruction without emitting it.

## Test plan
- ADD r1,r2 (0xE0821003), pc=0x100, out_ready=1 → one cycle later: out_valid=1, alu=0100, rn=2, rd=1, reg_we=1, s=0.
- BL +0x10 (0xEB000004) at pc=0x200 → bv=0x218, ib=1, bl=1; the next 2 in_valid beats are consumed with no output; the 3rd beat is emitted.
- ADDS (0xE0921003), then MOVEQ (0x03A01001) → MOVEQ held (in_ready=0) until a flags_wb pulse; then it is evaluated with cpsr Z=1 and emitted; with Z=0 it is consumed silently.
- MAX_PEND=3: issue 4 back-to-back ADDS → the 4th stalls until flags_wb; simultaneous flags_wb plus ADDS acceptance keeps pcnt unchanged.
- out_ready=0 with out_valid=1 holding ADDS, then flush → out_valid=0 next cycle, pcnt decremented, in_ready=0 during the flush cycle; rst_n low mid-stream clears all outputs immediately.
